// File: rtl/lfsr_symbol_modulator.sv
// Paces an external 5-bit LFSR, latches its bit 0 as the current symbol, and
// modulates the DDS sample stream with it (ASK, BPSK, FSK or pass-through).
module lfsr_symbol_modulator #(
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned DIV_W   = 26,
    parameter int unsigned DIVISOR = 50_000_000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [4:0]               lfsr_q,
    output logic                     lfsr_en,
    input  logic signed [DATA_W-1:0] sin_in,
    input  logic signed [DATA_W-1:0] alt_in,
    input  logic                     sample_valid,
    input  logic [1:0]               mode,
    output logic signed [DATA_W-1:0] mod_out,
    output logic                     mod_valid,
    output logic                     bit_out,
    output logic [15:0]              sym_count
);

    localparam int unsigned SYM_W = 16;
    localparam logic [DIV_W-1:0] TIMER_LAST = DIV_W'(DIVISOR - 1);
    localparam logic [DIV_W-1:0] TIMER_PRE  = DIV_W'(DIVISOR - 2);
    localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    localparam logic [1:0] MODE_ASK  = 2'd0;
    localparam logic [1:0] MODE_BPSK = 2'd1;
    localparam logic [1:0] MODE_FSK  = 2'd2;

    typedef enum logic {
        S_RUN     = 1'b0,
        S_CAPTURE = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       w_capture;
    logic [DIV_W-1:0]           r_timer;
    logic                       r_lfsr_en;
    logic                       r_bit;
    logic [1:0]                 r_mode;
    logic [SYM_W-1:0]           r_sym_count;
    logic signed [DATA_W-1:0]   r_mod_out;
    logic                       r_mod_valid;
    logic signed [DATA_W-1:0]   w_neg;
    logic signed [DATA_W-1:0]   w_mod;
    logic                       w_unused_lfsr;

    assign w_unused_lfsr = ^lfsr_q[4:1];

    // Symbol timer; the strobe register is set one count early so it is high
    // exactly while the timer holds DIVISOR-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer   <= '0;
            r_lfsr_en <= 1'b0;
        end else begin
            r_timer   <= (r_timer == TIMER_LAST) ? '0 : r_timer + DIV_W'(1);
            r_lfsr_en <= (r_timer == TIMER_PRE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            S_RUN: begin
                if (r_lfsr_en) begin
                    w_state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_capture    = 1'b1;
                w_state_next = S_RUN;
            end
            default: w_state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit       <= 1'b0;
            r_mode      <= MODE_ASK;
            r_sym_count <= '0;
        end else if (w_capture) begin
            r_bit       <= lfsr_q[0];
            r_mode      <= mode;
            r_sym_count <= r_sym_count + SYM_W'(1);
        end
    end

    // Saturating negation: the most negative code has no positive twin.
    always_comb begin
        w_neg = (sin_in == S_MIN) ? S_MAX : DATA_W'(-sin_in);
        w_mod = sin_in;
        case (r_mode)
            MODE_ASK:  w_mod = r_bit ? sin_in : '0;
            MODE_BPSK: w_mod = r_bit ? sin_in : w_neg;
            MODE_FSK:  w_mod = r_bit ? sin_in : alt_in;
            default:   w_mod = sin_in;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mod_out   <= '0;
            r_mod_valid <= 1'b0;
        end else begin
            r_mod_valid <= sample_valid;
            if (sample_valid) begin
                r_mod_out <= w_mod;
            end
        end
    end

    assign lfsr_en   = r_lfsr_en;
    assign bit_out   = r_bit;
    assign sym_count = r_sym_count;
    assign mod_out   = r_mod_out;
    assign mod_valid = r_mod_valid;

endmodule

// File: tb/tb_lfsr_symbol_modulator.sv
// Scoreboard bench for lfsr_symbol_modulator with a short symbol period and a
// bench-side LFSR stepped by the DUT strobe.
module tb_lfsr_symbol_modulator;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned DIV_W  = 26;
    localparam int          DIV    = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [4:0]               lfsr_q;
    logic                     lfsr_en;
    logic signed [DATA_W-1:0] sin_in;
    logic signed [DATA_W-1:0] alt_in;
    logic                     sample_valid;
    logic [1:0]               mode;
    logic signed [DATA_W-1:0] mod_out;
    logic                     mod_valid;
    logic                     bit_out;
    logic [15:0]              sym_count;

    lfsr_symbol_modulator #(
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W),
        .DIVISOR(DIV)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .lfsr_q      (lfsr_q),
        .lfsr_en     (lfsr_en),
        .sin_in      (sin_in),
        .alt_in      (alt_in),
        .sample_valid(sample_valid),
        .mode        (mode),
        .mod_out     (mod_out),
        .mod_valid   (mod_valid),
        .bit_out     (bit_out),
        .sym_count   (sym_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_sat    = 0;

    int          cyc;
    logic        m_bit;
    logic [1:0]  m_mode;
    logic [15:0] m_sym;
    logic [4:0]  m_lfsr;
    int          last_out;
    logic        exp_valid;
    int          exp_q[$];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [4:0] lfsr_step(input logic [4:0] q);
        return {q[3:0], q[4] ^ q[2]};
    endfunction

    function automatic int ref_mod(input logic b, input logic [1:0] md,
                                   input int s, input int a);
        case (md)
            2'd0:    return b ? s : 0;
            2'd1:    return b ? s : ((s == -2048) ? 2047 : -s);
            2'd2:    return b ? s : a;
            default: return s;
        endcase
    endfunction

    // One clock: update the reference from pre-edge values, then compare.
    task automatic tick();
        int e;
        exp_valid = 1'b0;
        if (!reset && sample_valid) begin
            e = ref_mod(m_bit, m_mode, int'(sin_in), int'(alt_in));
            if (e == 2047) n_sat++;
            exp_q.push_back(e);
            exp_valid = 1'b1;
        end
        if (cyc % DIV == DIV - 1) m_lfsr = lfsr_step(m_lfsr);
        if (reset) begin
            cyc = 0; m_bit = 1'b0; m_mode = 2'd0; m_sym = '0;
            exp_q.delete();
            last_out = 0;
        end else begin
            if (cyc > 0 && cyc % DIV == 0) begin
                m_bit  = lfsr_q[0];
                m_mode = mode;
                m_sym  = m_sym + 16'd1;
            end
            cyc++;
        end
        @(posedge clk);
        #1;
        lfsr_q = m_lfsr;
        check_eq("lfsr_en", int'(lfsr_en), int'(cyc % DIV == DIV - 1));
        check_eq("bit_out", int'(bit_out), int'(m_bit));
        check_eq("sym_count", int'(sym_count), int'(m_sym));
        check_eq("mod_valid", int'(mod_valid), int'(exp_valid));
        if (mod_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("mod_out_unexpected", int'(mod_out), last_out);
            end else begin
                last_out = exp_q.pop_front();
                check_eq("mod_out", int'(mod_out), last_out);
            end
        end else begin
            check_eq("mod_out_hold", int'(mod_out), last_out);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b1; lfsr_q = 5'b00001; m_lfsr = 5'b00001;
        sin_in = '0; alt_in = '0; sample_valid = 1'b0; mode = 2'd0;
        cyc = 0; m_bit = 1'b0; m_mode = 2'd0; m_sym = '0; last_out = 0;
        run(2);
        reset = 1'b0;
        run(13);

        sin_in = DATA_W'(1000); sample_valid = 1'b1;
        run(40);
        mode = 2'd1;
        run(40);

        sin_in = DATA_W'(-2048); alt_in = DATA_W'(-500);
        mode = 2'd2;
        run(40);
        mode = 2'd3;
        run(40);
        mode = 2'd1;
        run(40);

        // Samples only on capture edges while the mode changes mid-symbol.
        for (int i = 0; i < 24; i++) begin
            sample_valid = (cyc > 0 && cyc % DIV == 0);
            if (cyc % DIV == 2) mode = mode + 2'd1;
            tick();
        end

        for (int i = 0; i < 40; i++) begin
            sample_valid = 1'($urandom_range(0, 1));
            sin_in = DATA_W'($urandom_range(0, 4095));
            alt_in = DATA_W'($urandom_range(0, 4095));
            if (i % 7 == 3) mode = 2'($urandom_range(0, 3));
            tick();
        end

        // Reset landing one cycle before a strobe.
        sample_valid = 1'b1; sin_in = DATA_W'(300); mode = 2'd0;
        while (cyc % DIV != 2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run(12);

        check_eq("saturation_seen", int'(n_sat > 0), 1);
        check_eq("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_symbol_modulator.md
# lfsr_symbol_modulator

Downstream consumer of the 5-bit LFSR pattern generator. It paces the LFSR with a one-cycle advance strobe every DIVISOR clocks, captures the LFSR's bit 0 as the current symbol, and modulates the DDS sample stream with that symbol in one of four modes: ASK, BPSK, FSK or pass-through. Its output feeds the DAC/scope path.

## Interface
- DATA_W, 12: width of the signed DDS samples and of the modulated output.
- DIV_W, 26: width of the symbol timer.
- DIVISOR, 50_000_000: clocks per symbol (1 Hz at 50 MHz). Legal range is 4 to 2^DIV_W-1.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- lfsr_q  in  5  current LFSR state; only bit 0 is used.
- lfsr_en  out  1  one-cycle advance strobe to the LFSR.
- sin_in  in  DATA_W  signed primary tone sample.
- alt_in  in  DATA_W  signed secondary tone sample, used for FSK.
- sample_valid  in  1  high for one cycle when sin_in and alt_in are valid.
- mode  in  2  modulation select: 0 ASK, 1 BPSK, 2 FSK, 3 pass-through.
- mod_out  out  DATA_W  signed modulated sample, registered.
- mod_valid  out  1  high for one cycle when mod_out updates.
- bit_out  out  1  current symbol bit, registered.
- sym_count  out  16  number of symbols latched; wraps.

## Operation
- The symbol timer counts 0 to DIVISOR-1 and wraps. lfsr_en is high exactly in the cycle where the timer equals DIVISOR-1.
- The FSM has two states, RUN and CAPTURE.
  - RUN to CAPTURE: on the edge that ends an lfsr_en cycle. The LFSR updates on that same edge.
  - CAPTURE to RUN: unconditionally after one cycle. At that edge bit_out <= lfsr_q[0], mode_r <= mode, and sym_count increments (modulo 2^16).
- Mode is used only through mode_r. Changes on mode mid-symbol have no effect until the next capture.
- On every edge where sample_valid=1, mod_out is computed from the bit_out and mode_r values held before that edge:
  - ASK: bit ? sin_in : 0.
  - BPSK: bit ? sin_in : -sin_in. Negation saturates, so the most negative value maps to +(2^(DATA_W-1)-1). No wrap is allowed.
  - FSK: bit ? sin_in : alt_in.
  - Pass-through: sin_in, regardless of bit.
- mod_valid is a registered copy of sample_valid. When sample_valid=0, mod_out holds its value.
- Simultaneous events: if sample_valid and the CAPTURE edge coincide, that sample uses the old bit and old mode; the new symbol applies from the next sample.
- Reset values:
  - timer 0, FSM RUN.
  - lfsr_en 0, bit_out 0, mode_r 0 (ASK), sym_count 0.
  - mod_out 0, mod_valid 0.
- Reset mid-symbol: all state returns to reset values on that edge and the timer restarts from 0. No partial strobe is issued. Reset has priority over every other event.

## Timing
- Take edge 1 as the first rising edge with reset low. lfsr_en is high during the cycle after edge DIVISOR-1, i.e. following the (DIVISOR-1)th reset-low edge, then every DIVISOR cycles.
- Symbol latency: bit_out changes 2 edges after the edge where lfsr_en rises (1 edge for the LFSR update, 1 edge for capture).
- Sample latency: 1 cycle from sample_valid to mod_out/mod_valid. The path is fully pipelined and accepts a sample every cycle.
- sym_count and bit_out change on the same edge.
- lfsr_en is never high for two consecutive cycles.

## Test plan
- Reset and pacing, DIVISOR=4: hold reset for 2 edges, then release. Expect all outputs 0 during reset; lfsr_en high on cycles 3, 7, 11; sym_count reaching 1, 2, 3 two edges after each strobe.
- Capture: drive lfsr_q=5'b00001 with a model LFSR stepped by lfsr_en. Expect bit_out to track the model's bit 0 and to change only on CAPTURE edges.
- ASK/BPSK: sin_in=1000, sample_valid every cycle. Expect mode 0 to give 1000 when bit=1 and 0 when bit=0; mode 1 to give 1000 and -1000.
- FSK, pass-through and saturation: sin_in=-2048 (DATA_W=12), alt_in=-500.
  - Mode 2 gives -2048 (bit=1) and -500 (bit=0).
  - Mode 3 gives -2048 always.
  - Mode 1 with bit=0 gives +2047.
- Mode latch and coincidence: change mode mid-symbol and pulse sample_valid on the CAPTURE edge. Expect that sample to use the old mode and old bit, and the new mode to apply only from the next sample after capture.
- Reset mid-operation: assert reset one cycle before lfsr_en. Expect no strobe, all outputs 0 on the next edge, and the first strobe again on cycle 3 after release.
